spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter DATA, default 32, meaning the data word width.
REQ-002 SHALL have parameter ADDR, default 3, meaning the config width: bit0 CPOL, bit1 CPHA, bit2 slave select.
REQ-003 SHALL have parameter TIMEOUT, default 200, meaning the maximum number of WAIT cycles before abort.
REQ-004 SHALL have ports: clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have ports: presetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: req  in  2  per-requester transaction request, level; bit i = requester i.
REQ-007 SHALL have ports: wr_rdbar0/wr_rdbar1  in  1 each  1 = write, 0 = read.
REQ-008 SHALL have ports: wdata0/wdata1  in  DATA each  write payload.
REQ-009 SHALL have ports: cfg0/cfg1  in  ADDR each  mode and slave select.
REQ-010 SHALL have ports: gnt  out  2  one-hot grant, held for the whole transaction.
REQ-011 SHALL have ports: done  out  2  one-cycle completion pulse per requester.
REQ-012 SHALL have ports: err  out  1  one-cycle pulse, coincident with done, on timeout.
REQ-013 SHALL have ports: rdata  out  DATA  captured read data.
REQ-014 SHALL have ports: spe, m_wr_rdbar, master_control  out  1 each; m_wdata  out  DATA; m_addr  out  ADDR  (SPI master command side).
REQ-015 SHALL have ports: txc  in  1  master transfer-complete level; m_rdata  in  DATA  master read data.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-017 IDLE: if req != 0, SHALL select a winner, latch its wr_rdbar/wdata/cfg into command registers, set gnt, and go to START; otherwise SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin via a last-grant pointer: a single request always wins; if both request, the requester not granted last wins.
REQ-019 Pointer SHALL update only at grant time.
REQ-020 START: SHALL drive spe=1, m_wr_rdbar = latched wr_rdbar, master_control = latched wr_rdbar, m_wdata/m_addr = latched values; SHALL clear the timeout counter and sample txc into txc_q; SHALL go to WAIT after 1 cycle.
REQ-021 spe, m_wr_rdbar, master_control, m_wdata and m_addr SHALL hold constant from START through WAIT and SHALL come from registers only.
REQ-022 WAIT: completion SHALL be a txc rising edge (txc=1, txc_q=0), not txc level.
REQ-023 WAIT: on completion, SHALL go to DONE.
REQ-024 WAIT: without completion, SHALL increment the counter; at counter == TIMEOUT-1, SHALL go to DONE with an abort flag set.
REQ-025 DONE (1 cycle): SHALL pulse done[granted]=1.
REQ-026 DONE: for a read with no abort, SHALL load rdata <= m_rdata in that cycle.
REQ-027 DONE: if aborted, SHALL pulse err=1 and leave rdata unchanged.
REQ-028 DONE: SHALL drive spe=0, master_control=0, gnt=0, then go to IDLE.
REQ-029 IDLE SHALL keep spe=0, so spe is low for at least 1 cycle between back-to-back transactions.
REQ-030 Latency: req seen in IDLE at edge N -> gnt and spe high after edge N; done high in the cycle after the edge that detects the txc rise.
REQ-031 Deasserting req after grant SHALL NOT abort the transaction; the command SHALL remain committed.
REQ-032 req still high after done SHALL be re-arbitrated in IDLE as a new request.
REQ-033 Input changes to wdata/cfg/wr_rdbar after grant SHALL be ignored.
REQ-034 txc already high on entry to WAIT SHALL NOT count as completion until it falls and rises again.
REQ-035 Counter SHALL be ceil(log2(TIMEOUT))+1 bits wide and SHALL saturate; no wrap-around.

Reset
REQ-036 presetn=0 at any time, including mid-WAIT, SHALL immediately force state=IDLE; gnt=0, done=0, err=0, spe=0, m_wr_rdbar=0, master_control=0, m_wdata=0, m_addr=0, rdata=0; counter=0; txc_q=0; pointer=1 (requester 0 wins the first tie).
REQ-037 After presetn release, the first arbitration SHALL occur on the first rising clk edge with req != 0.

Verification
REQ-038 After reset, req=2'b11 held; txc pulse each transaction -> gnt sequence 01, 10, 01, 10; done alternates in the same order.
REQ-039 req=01, wr_rdbar0=1, wdata0=32'hA5A5_F00F, cfg0=3'b101 -> m_wdata=A5A5F00F, m_addr=101, master_control=1, spe=1 until txc rises; done=01; rdata unchanged.
REQ-040 req=10, wr_rdbar1=0, m_rdata=32'h1234_5678 at txc rise -> done=10 and rdata=12345678 in the same cycle.
REQ-041 Grant with txc never rising, TIMEOUT=200 -> exactly 200 WAIT cycles, then done and err pulse together; spe=0 the next cycle.
REQ-042 presetn low mid-WAIT -> all outputs at reset values asynchronously; no done pulse; the next request is granted normally.
REQ-043 txc held high before grant, then low, then high -> done only after the second rise; wdata0 changed during WAIT -> m_wdata stays at the latched value.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin front end for a single SPI master.
// A winning request has its mode, slave select and payload latched into
// command registers. The command is held on the master side until the
// master signals completion (a rising edge on txc) or a wait timeout
// expires. The requester then gets a one-cycle done pulse.
//
// Ports
//   clk, presetn          clock (rising edge), asynchronous active-low reset
//   req[1:0]              per-requester request level
//   wr_rdbar0/1           1 = write, 0 = read
//   wdata0/1, cfg0/1      write payload and config {slave select, CPHA, CPOL}
//   gnt[1:0]              one-hot grant, held for the whole transaction
//   done[1:0], err        one-cycle completion pulse; err marks a timeout abort
//   rdata                 read data captured on a successful read
//   spe, m_wr_rdbar, master_control, m_wdata, m_addr   command to SPI master
//   txc, m_rdata          transfer-complete level and read data from master
module spi_arbiter #(
  parameter int DATA    = 32,
  parameter int ADDR    = 3,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            presetn,
  input  logic [1:0]      req,
  input  logic            wr_rdbar0,
  input  logic            wr_rdbar1,
  input  logic [DATA-1:0] wdata0,
  input  logic [DATA-1:0] wdata1,
  input  logic [ADDR-1:0] cfg0,
  input  logic [ADDR-1:0] cfg1,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic            err,
  output logic [DATA-1:0] rdata,
  output logic            spe,
  output logic            m_wr_rdbar,
  output logic            master_control,
  output logic [DATA-1:0] m_wdata,
  output logic [ADDR-1:0] m_addr,
  input  logic            txc,
  input  logic [DATA-1:0] m_rdata
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;       // requester granted most recently
  logic          owner;      // requester holding the current grant
  logic [CW-1:0] cnt;
  logic          txc_q;
  logic          winner;
  logic          txc_rise;
  logic          grant_now;
  logic          finish_now;
  logic          abort_now;

  // Completion is an edge, so a txc level left high from an earlier
  // transfer cannot complete a new transaction.
  assign txc_rise = txc & ~txc_q;

  // A lone request wins outright; on a tie the requester not served last wins.
  assign winner = (req == 2'b11) ? ~last : req[1];

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_now  = 1'b0;
    finish_now = 1'b0;
    abort_now  = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_now = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (txc_rise) begin
          finish_now = 1'b1;
          state_nxt  = DONE;
        end else if (cnt == CNT_LAST) begin
          finish_now = 1'b1;
          abort_now  = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered and change on the edges entering START (grant)
  // and entering DONE (finish), so the master side never sees comb glitches.
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      gnt            <= 2'b00;
      done           <= 2'b00;
      err            <= 1'b0;
      rdata          <= '0;
      spe            <= 1'b0;
      m_wr_rdbar     <= 1'b0;
      master_control <= 1'b0;
      m_wdata        <= '0;
      m_addr         <= '0;
      cnt            <= '0;
      txc_q          <= 1'b0;
      last           <= 1'b1;
      owner          <= 1'b0;
    end else begin
      txc_q <= txc;
      done  <= 2'b00;
      err   <= 1'b0;

      if (state == START)
        cnt <= '0;
      else if (state == WAIT && cnt != CNT_MAX)
        cnt <= cnt + CW'(1);

      if (grant_now) begin
        last           <= winner;
        owner          <= winner;
        gnt            <= {winner, ~winner};
        spe            <= 1'b1;
        m_wr_rdbar     <= winner ? wr_rdbar1 : wr_rdbar0;
        master_control <= winner ? wr_rdbar1 : wr_rdbar0;
        m_wdata        <= winner ? wdata1 : wdata0;
        m_addr         <= winner ? cfg1 : cfg0;
      end

      if (finish_now) begin
        gnt            <= 2'b00;
        spe            <= 1'b0;
        master_control <= 1'b0;
        done           <= {owner, ~owner};
        err            <= abort_now;
        if (!abort_now && !m_wr_rdbar)
          rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        presetn = 1'b1;
  logic [1:0]  req = 2'b00;
  logic        wr_rdbar0 = 1'b0, wr_rdbar1 = 1'b0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [2:0]  cfg0 = '0, cfg1 = '0;
  logic [1:0]  gnt, done;
  logic        err, spe, m_wr_rdbar, master_control;
  logic [31:0] rdata, m_wdata;
  logic [2:0]  m_addr;
  logic        txc = 1'b0;
  logic [31:0] m_rdata = '0;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int          exp_last = 1;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  spi_arbiter dut (
    .clk(clk), .presetn(presetn), .req(req),
    .wr_rdbar0(wr_rdbar0), .wr_rdbar1(wr_rdbar1),
    .wdata0(wdata0), .wdata1(wdata1), .cfg0(cfg0), .cfg1(cfg1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .spe(spe), .m_wr_rdbar(m_wr_rdbar), .master_control(master_control),
    .m_wdata(m_wdata), .m_addr(m_addr), .txc(txc), .m_rdata(m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round robin: lone request wins, tie goes to the one not served last.
  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return (r == 2'b10) ? 1 : 0;
  endfunction

  task automatic test_reset();
    #3 presetn = 1'b0;
    #1;
    n_cmp++; if ({gnt, done, err, spe, m_wr_rdbar, master_control} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl got=%b want=0", {gnt, done, err, spe, m_wr_rdbar, master_control}); end
    tick(); tick();
    n_cmp++; if ({m_wdata, m_addr, rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h/%h/%h want=0", m_wdata, m_addr, rdata); end
    presetn = 1'b1;
    exp_last = 1; exp_rdata = '0;
    tick(); tick();
    n_cmp++; if (gnt !== 2'b00 || spe !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req got gnt=%b spe=%b want 00/0", gnt, spe); end
  endtask

  task automatic test_round_robin();
    int w;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wr_rdbar0 = 1'($urandom_range(0, 1)); wr_rdbar1 = 1'($urandom_range(0, 1));
      wdata0 = $urandom; wdata1 = $urandom;
      w = pick(req, exp_last); exp_last = w;
      tick();
      n_cmp++; if (gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10) || gnt !== 2'(1 << w)) begin
        n_fail++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, gnt, 2'(1 << w)); end
      tick();
      m_rdata = $urandom; txc = 1'b1;
      tick();
      if ((w == 0 ? wr_rdbar0 : wr_rdbar1) == 1'b0) exp_rdata = m_rdata;
      n_cmp++; if (done !== 2'(1 << w) || err !== 1'b0 || rdata !== exp_rdata) begin
        n_fail++; $display("FAIL rr_done[%0d] got=%b/%b/%h want=%b/0/%h", i, done, err, rdata, 2'(1 << w), exp_rdata); end
      txc = 1'b0;
      tick();
      n_cmp++; if (done !== 2'b00 || spe !== 1'b0) begin
        n_fail++; $display("FAIL rr_idle[%0d] got done=%b spe=%b want 00/0", i, done, spe); end
    end
    req = 2'b00;
  endtask

  task automatic test_write();
    req = 2'b01; wr_rdbar0 = 1'b1; wdata0 = 32'hA5A5_F00F; cfg0 = 3'b101;
    exp_last = pick(req, exp_last);
    tick();
    n_cmp++; if (gnt !== 2'b01 || spe !== 1'b1 || master_control !== 1'b1 || m_wr_rdbar !== 1'b1) begin
      n_fail++; $display("FAIL wr_cmd got gnt=%b spe=%b mc=%b wr=%b want 01/1/1/1", gnt, spe, master_control, m_wr_rdbar); end
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (m_wdata !== 32'hA5A5_F00F || m_addr !== 3'b101 || spe !== 1'b1 || done !== 2'b00) begin
        n_fail++; $display("FAIL wr_hold[%0d] got %h/%b/%b/%b want a5a5f00f/101/1/00", i, m_wdata, m_addr, spe, done); end
    end
    m_rdata = 32'hDEAD_BEEF; txc = 1'b1;
    tick();
    n_cmp++; if (done !== 2'b01 || rdata !== exp_rdata || spe !== 1'b0 || master_control !== 1'b0) begin
      n_fail++; $display("FAIL wr_done got done=%b rdata=%h spe=%b mc=%b want 01/%h/0/0", done, rdata, spe, master_control, exp_rdata); end
    txc = 1'b0;
    tick();
  endtask

  task automatic test_read();
    req = 2'b10; wr_rdbar1 = 1'b0; cfg1 = 3'b010;
    exp_last = pick(req, exp_last);
    tick();
    n_cmp++; if (gnt !== 2'b10 || m_wr_rdbar !== 1'b0 || master_control !== 1'b0 || m_addr !== 3'b010) begin
      n_fail++; $display("FAIL rd_cmd got gnt=%b wr=%b mc=%b addr=%b want 10/0/0/010", gnt, m_wr_rdbar, master_control, m_addr); end
    req = 2'b00;
    tick(); tick();
    m_rdata = 32'h1234_5678; txc = 1'b1;
    tick();
    exp_rdata = 32'h1234_5678;
    n_cmp++; if (done !== 2'b10 || rdata !== 32'h1234_5678 || err !== 1'b0) begin
      n_fail++; $display("FAIL rd_done got done=%b rdata=%h err=%b want 10/12345678/0", done, rdata, err); end
    txc = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    req = 2'b01; wr_rdbar0 = 1'b0; m_rdata = 32'h0BAD_0BAD;
    exp_last = pick(req, exp_last);
    tick();
    req = 2'b00;
    tick();
    for (int i = 0; i < 199; i++) begin
      if (done !== 2'b00 || err !== 1'b0) early++;
      tick();
    end
    n_cmp++; if (early != 0 || done !== 2'b00 || spe !== 1'b1) begin
      n_fail++; $display("FAIL to_early got early=%0d done=%b spe=%b want 0/00/1", early, done, spe); end
    tick();
    n_cmp++; if (done !== 2'b01 || err !== 1'b1 || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL to_abort got done=%b err=%b rdata=%h want 01/1/%h", done, err, rdata, exp_rdata); end
    tick();
    n_cmp++; if (spe !== 1'b0 || err !== 1'b0 || done !== 2'b00) begin
      n_fail++; $display("FAIL to_after got spe=%b err=%b done=%b want 0/0/00", spe, err, done); end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    req = 2'b10; wr_rdbar1 = 1'b1; wdata1 = 32'hCAFE_0001;
    tick(); tick(); tick(); tick();
    #2 presetn = 1'b0;
    #1;
    n_cmp++; if ({gnt, done, err, spe, m_wr_rdbar, master_control} !== 8'h00 || {m_wdata, m_addr, rdata} !== '0) begin
      n_fail++; $display("FAIL rst_async got ctrl=%b data=%h/%h/%h want 0", {gnt, done, err, spe, m_wr_rdbar, master_control}, m_wdata, m_addr, rdata); end
    req = 2'b00; txc = 1'b1;
    tick();
    n_cmp++; if (done !== 2'b00 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_nodone got done=%b err=%b want 00/0", done, err); end
    txc = 1'b0;
    presetn = 1'b1;
    exp_last = 1; exp_rdata = '0;
    req = 2'b11; wr_rdbar0 = 1'b1; wdata0 = 32'h7777_0000;
    w = pick(req, exp_last); exp_last = w;
    tick();
    n_cmp++; if (gnt !== 2'(1 << w) || spe !== 1'b1 || m_wdata !== 32'h7777_0000) begin
      n_fail++; $display("FAIL rst_regrant got gnt=%b spe=%b wd=%h want %b/1/77770000", gnt, spe, m_wdata, 2'(1 << w)); end
    req = 2'b00;
    tick();
    txc = 1'b1;
    tick();
    n_cmp++; if (done !== 2'b01) begin
      n_fail++; $display("FAIL rst_done got=%b want=01", done); end
    txc = 1'b0;
    tick();
  endtask

  task automatic test_txc_high();
    txc = 1'b1;
    req = 2'b01; wr_rdbar0 = 1'b1; wdata0 = 32'h1111_2222;
    exp_last = pick(req, exp_last);
    tick();
    req = 2'b00;
    tick();
    wdata0 = 32'h3333_4444;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (done !== 2'b00 || m_wdata !== 32'h1111_2222) begin
        n_fail++; $display("FAIL txh_level[%0d] got done=%b wd=%h want 00/11112222", i, done, m_wdata); end
    end
    txc = 1'b0;
    tick();
    n_cmp++; if (done !== 2'b00 || spe !== 1'b1) begin
      n_fail++; $display("FAIL txh_fall got done=%b spe=%b want 00/1", done, spe); end
    txc = 1'b1;
    tick();
    n_cmp++; if (done !== 2'b01 || err !== 1'b0) begin
      n_fail++; $display("FAIL txh_rise got done=%b err=%b want 01/0", done, err); end
    txc = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int          w, k;
    logic        e_wr;
    logic [31:0] e_wd;
    logic [2:0]  e_cfg;
    for (int it = 0; it < 40; it++) begin
      req = 2'($urandom_range(1, 3));
      wr_rdbar0 = 1'($urandom_range(0, 1)); wr_rdbar1 = 1'($urandom_range(0, 1));
      wdata0 = $urandom; wdata1 = $urandom;
      cfg0 = 3'($urandom); cfg1 = 3'($urandom);
      w = pick(req, exp_last); exp_last = w;
      e_wr  = (w == 0) ? wr_rdbar0 : wr_rdbar1;
      e_wd  = (w == 0) ? wdata0 : wdata1;
      e_cfg = (w == 0) ? cfg0 : cfg1;
      tick();
      n_cmp++; if (gnt !== 2'(1 << w) || spe !== 1'b1 || m_wdata !== e_wd || m_addr !== e_cfg
                   || m_wr_rdbar !== e_wr || master_control !== e_wr) begin
        n_fail++; $display("FAIL rnd_cmd[%0d] got %b/%b/%h/%b/%b/%b want %b/1/%h/%b/%b/%b", it,
          gnt, spe, m_wdata, m_addr, m_wr_rdbar, master_control, 2'(1 << w), e_wd, e_cfg, e_wr, e_wr); end
      req = 2'($urandom_range(0, 3));
      wr_rdbar0 = ~wr_rdbar0; wr_rdbar1 = ~wr_rdbar1;
      wdata0 = $urandom; wdata1 = $urandom; cfg0 = ~cfg0; cfg1 = ~cfg1;
      tick();
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) tick();
      n_cmp++; if (done !== 2'b00 || m_wdata !== e_wd || m_addr !== e_cfg || m_wr_rdbar !== e_wr || gnt !== 2'(1 << w)) begin
        n_fail++; $display("FAIL rnd_hold[%0d] got done=%b wd=%h addr=%b wr=%b gnt=%b want 00/%h/%b/%b/%b", it,
          done, m_wdata, m_addr, m_wr_rdbar, gnt, e_wd, e_cfg, e_wr, 2'(1 << w)); end
      m_rdata = $urandom; txc = 1'b1;
      tick();
      if (!e_wr) exp_rdata = m_rdata;
      n_cmp++; if (done !== 2'(1 << w) || err !== 1'b0 || rdata !== exp_rdata || spe !== 1'b0) begin
        n_fail++; $display("FAIL rnd_done[%0d] got done=%b err=%b rdata=%h spe=%b want %b/0/%h/0", it,
          done, err, rdata, spe, 2'(1 << w), exp_rdata); end
      txc = 1'b0;
      tick();
      n_cmp++; if (done !== 2'b00 || spe !== 1'b0 || gnt !== 2'b00) begin
        n_fail++; $display("FAIL rnd_idle[%0d] got done=%b spe=%b gnt=%b want 00/0/00", it, done, spe, gnt); end
    end
    req = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_read();
    test_timeout();
    test_reset_mid_wait();
    test_txc_high();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
